// File: rtl/layer_arb_pkg.sv
// Types shared by the layer-engine share arbiter and its round-robin picker.
package layer_arb_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} arb_state_t;
  typedef logic req_id_t;
  localparam int NUM_REQ = 2;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: prio breaks the tie when both clients request.
// Latency: purely combinational.
// Backpressure: none; it only proposes a winner and the caller decides when to latch it.
module rr_arb2
  import layer_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  req_id_t            prio,
  output logic               gnt_valid,
  output req_id_t            gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = 1'b0;
    if (req == 2'b11) begin
      gnt_id = prio;
    end else if (req[1]) begin
      gnt_id = 1'b1;
    end
  end

endmodule

// File: rtl/layer_share_arb.sv
// Shares one layer engine between two clients, one whole N-in / M-out transaction at a time.
// Latency: one cycle from request to grant, then zero-cycle pass-through in both directions.
// Backpressure: ready/valid passed straight through to the owning client; the other client sees ready=0.
module layer_share_arb
  import layer_arb_pkg::*;
#(
  parameter int M    = 16,
  parameter int N    = 8,
  parameter int T    = 16,
  parameter int logN = $clog2(N + 1),
  parameter int logM = $clog2(M + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s0_valid,
  output logic         s0_ready,
  input  logic [T-1:0] s0_data,
  input  logic         s1_valid,
  output logic         s1_ready,
  input  logic [T-1:0] s1_data,
  output logic         m0_valid,
  input  logic         m0_ready,
  output logic [T-1:0] m0_data,
  output logic         m1_valid,
  input  logic         m1_ready,
  output logic [T-1:0] m1_data,
  output logic         eng_s_valid,
  input  logic         eng_s_ready,
  output logic [T-1:0] eng_data_in,
  input  logic         eng_m_valid,
  output logic         eng_m_ready,
  input  logic [T-1:0] eng_data_out,
  output logic         grant,
  output logic         busy
);

  localparam logic [logN-1:0] IN_LAST  = logN'(N - 1);
  localparam logic [logM-1:0] OUT_LAST = logM'(M - 1);

  arb_state_t          state;
  logic [logN-1:0]     in_cnt;
  logic [logM-1:0]     out_cnt;
  req_id_t             prio;
  logic [NUM_REQ-1:0]  req;
  logic                gnt_valid;
  req_id_t             gnt_id;
  logic                in_xfer;
  logic                out_xfer;

  assign req = {s1_valid, s0_valid};

  rr_arb2 u_pick (
    .req       (req),
    .prio      (prio),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign in_xfer  = eng_s_valid && eng_s_ready;
  assign out_xfer = eng_m_valid && eng_m_ready;

  // grant/busy are registered here so they are glitch-free; grant is cleared on completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      in_cnt  <= '0;
      out_cnt <= '0;
      prio    <= 1'b0;
      grant   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            grant <= gnt_id;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (in_xfer) begin
            if (in_cnt == IN_LAST) begin
              in_cnt <= '0;
              state  <= DRAIN;
            end else begin
              in_cnt <= in_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_xfer) begin
            if (out_cnt == OUT_LAST) begin
              out_cnt <= '0;
              prio    <= ~grant;
              grant   <= 1'b0;
              busy    <= 1'b0;
              state   <= IDLE;
            end else begin
              out_cnt <= out_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s0_ready    = 1'b0;
    s1_ready    = 1'b0;
    m0_valid    = 1'b0;
    m1_valid    = 1'b0;
    m0_data     = '0;
    m1_data     = '0;
    eng_s_valid = 1'b0;
    eng_data_in = '0;
    eng_m_ready = 1'b0;
    case (state)
      LOAD: begin
        if (grant == 1'b0) begin
          eng_s_valid = s0_valid;
          eng_data_in = s0_data;
          s0_ready    = eng_s_ready;
        end else begin
          eng_s_valid = s1_valid;
          eng_data_in = s1_data;
          s1_ready    = eng_s_ready;
        end
      end
      DRAIN: begin
        if (grant == 1'b0) begin
          m0_valid    = eng_m_valid;
          m0_data     = eng_data_out;
          eng_m_ready = m0_ready;
        end else begin
          m1_valid    = eng_m_valid;
          m1_data     = eng_data_out;
          eng_m_ready = m1_ready;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_layer_share_arb.sv
// Randomized bench for layer_share_arb: a transaction-level model predicts every output each cycle.
module tb_layer_share_arb;

  localparam int M = 16;
  localparam int N = 8;
  localparam int T = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   sv;
  logic [1:0]   mr;
  logic [T-1:0] sd [2];
  logic         eng_s_ready, eng_m_valid;
  logic [T-1:0] eng_data_out;
  logic         s0_ready, s1_ready, m0_valid, m1_valid, eng_s_valid, eng_m_ready, grant, busy;
  logic [T-1:0] m0_data, m1_data, eng_data_in;

  always #5 clk = ~clk;

  layer_share_arb #(.M(M), .N(N), .T(T)) dut (
    .clk(clk), .reset(reset),
    .s0_valid(sv[0]), .s0_ready(s0_ready), .s0_data(sd[0]),
    .s1_valid(sv[1]), .s1_ready(s1_ready), .s1_data(sd[1]),
    .m0_valid(m0_valid), .m0_ready(mr[0]), .m0_data(m0_data),
    .m1_valid(m1_valid), .m1_ready(mr[1]), .m1_data(m1_data),
    .eng_s_valid(eng_s_valid), .eng_s_ready(eng_s_ready), .eng_data_in(eng_data_in),
    .eng_m_valid(eng_m_valid), .eng_m_ready(eng_m_ready), .eng_data_out(eng_data_out),
    .grant(grant), .busy(busy)
  );

  int tests, fails;

  // Reference model: owner (-1 = nobody), words accepted, results delivered, tie-break priority.
  int own, nin, nout, prio;

  // Stimulus knobs and engine model state.
  int           left [2];
  int           mr_mode;
  bit           sready_rand, eng_rand, eng_seq, early;
  int           eng_cnt, eng_pend;
  logic [T-1:0] eng_next;

  logic [T-1:0] exp_in[$], got_in[$], exp_r0[$], got_r0[$], exp_r1[$], got_r1[$];
  int           got_gnt[$];
  logic         prev_busy;
  bit           dsx [2];
  bit           dein, deout;
  logic [55:0]  exp_v, obs_v;

  function automatic logic [55:0] model_outputs();
    logic [1:0]   sr  = '0;
    logic [1:0]   mv  = '0;
    logic         esv = 1'b0, emr = 1'b0, b = 1'b0, g = 1'b0;
    logic [T-1:0] edi = '0, md0 = '0, md1 = '0;
    if (own >= 0) begin
      b = 1'b1;
      g = own[0];
      if (nin < N) begin
        esv     = sv[own];
        edi     = sd[own];
        sr[own] = eng_s_ready;
      end else begin
        mv[own] = eng_m_valid;
        emr     = mr[own];
        if (own == 0) md0 = eng_data_out;
        else          md1 = eng_data_out;
      end
    end
    return {b, g, sr, mv, esv, emr, edi, md0, md1};
  endfunction

  function automatic void model_step();
    if (reset) begin
      own = -1; nin = 0; nout = 0; prio = 0;
    end else if (own < 0) begin
      if (sv != 2'b00) own = (sv == 2'b11) ? prio : (sv[0] ? 0 : 1);
    end else if (nin < N) begin
      if (sv[own] && eng_s_ready) begin
        exp_in.push_back(sd[own]);
        nin++;
      end
    end else if (eng_m_valid && mr[own]) begin
      if (own == 0) exp_r0.push_back(eng_data_out);
      else          exp_r1.push_back(eng_data_out);
      nout++;
      if (nout == M) begin
        prio = 1 - own; own = -1; nin = 0; nout = 0;
      end
    end
  endfunction

  function automatic int log_errors();
    int e = 0;
    if (got_in.size() != exp_in.size()) e++;
    else foreach (got_in[i]) if (got_in[i] !== exp_in[i]) e++;
    if (got_r0.size() != exp_r0.size()) e++;
    else foreach (got_r0[i]) if (got_r0[i] !== exp_r0[i]) e++;
    if (got_r1.size() != exp_r1.size()) e++;
    else foreach (got_r1[i]) if (got_r1[i] !== exp_r1[i]) e++;
    return e;
  endfunction

  function automatic bit all_done();
    return own < 0 && left[0] == 0 && left[1] == 0 && eng_pend == 0 && !eng_m_valid;
  endfunction

  task automatic clear_logs();
    exp_in.delete(); got_in.delete(); exp_r0.delete(); got_r0.delete();
    exp_r1.delete(); got_r1.delete(); got_gnt.delete();
  endtask

  task automatic next_result();
    eng_data_out = eng_seq ? eng_next : T'($urandom);
    eng_next     = eng_next + 1'b1;
  endtask

  // Called at posedge+1: waits to mid-cycle, snapshots DUT and model, then advances the model.
  task automatic settle();
    #4;
    exp_v = model_outputs();
    obs_v = {busy, grant, s1_ready, s0_ready, m1_valid, m0_valid, eng_s_valid, eng_m_ready,
             eng_data_in, m0_data, m1_data};
    dsx[0] = sv[0] && s0_ready;
    dsx[1] = sv[1] && s1_ready;
    dein   = eng_s_valid && eng_s_ready;
    deout  = eng_m_valid && eng_m_ready;
    if (dein) got_in.push_back(eng_data_in);
    if (m0_valid && mr[0]) got_r0.push_back(m0_data);
    if (m1_valid && mr[1]) got_r1.push_back(m1_data);
    if (busy && !prev_busy) got_gnt.push_back(int'(grant));
    prev_busy = busy;
    model_step();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      if (dsx[c]) begin
        sd[c] = sd[c] + 1'b1;
        left[c]--;
      end
      sv[c] = (left[c] > 0);
      case (mr_mode)
        0:       mr[c] = 1'b1;
        1:       mr[c] = 1'($urandom_range(0, 1));
        default: mr[c] = ~mr[c];
      endcase
    end
    if (dein) begin
      eng_cnt++;
      if (eng_cnt == N) begin
        eng_cnt  = 0;
        eng_pend += M;
      end
    end
    if (deout) begin
      eng_pend--;
      eng_m_valid = 1'b0;
      next_result();
    end
    if (eng_pend > 0) early = 1'b0;
    if (!eng_m_valid && (eng_pend > 0 || early) && (!eng_rand || $urandom_range(0, 1) == 1))
      eng_m_valid = 1'b1;
    eng_s_ready = sready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  task automatic setup(input int mrm, input bit srand, input bit erand, input bit eseq,
                       input logic [T-1:0] first);
    mr_mode = mrm; sready_rand = srand; eng_rand = erand; eng_seq = eseq;
    eng_next = first;
    next_result();
    clear_logs();
  endtask

  task automatic do_reset();
    reset = 1'b1; sv = 2'b00; left[0] = 0; left[1] = 0;
    eng_m_valid = 1'b0; eng_pend = 0; eng_cnt = 0; early = 1'b0; mr = 2'b11;
    repeat (2) begin
      settle();
      advance();
    end
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      settle();
      tests++;
      if (obs_v !== 56'h0) begin
        fails++;
        $display("FAIL reset_outputs cycle %0d got=%h want=0", i, obs_v);
      end
      tests++;
      if (obs_v !== exp_v) begin
        fails++;
        $display("FAIL reset_model cycle %0d got=%h want=%h", i, obs_v, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_single();
    bit fin = 0;
    int e;
    setup(0, 0, 0, 1, T'(100));
    sd[0] = T'(1); left[0] = N; sv[0] = 1'b1;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      settle();
      tests++;
      if (obs_v !== exp_v) begin
        fails++;
        $display("FAIL single_outputs t=%0t got=%h want=%h", $time, obs_v, exp_v);
      end
      fin = all_done();
      advance();
    end
    tests++;
    if (!fin) begin fails++; $display("FAIL single_timeout done=0 want=1"); end
    e = 0;
    if (got_r0.size() != M || got_in.size() != N || got_r1.size() != 0) e++;
    else begin
      foreach (got_r0[i]) if (got_r0[i] !== T'(100 + i)) e++;
      foreach (got_in[i]) if (got_in[i] !== T'(1 + i)) e++;
    end
    tests++;
    if (e != 0) begin
      fails++;
      $display("FAIL single_data errors=%0d r0=%0d in=%0d want 0/%0d/%0d", e, got_r0.size(), got_in.size(), M, N);
    end
  endtask

  task automatic test_alternate();
    bit fin = 0;
    int e;
    int want [4] = '{0, 1, 0, 1};
    do_reset();
    setup(1, 1, 1, 0, '0);
    left[0] = 2 * N; left[1] = 2 * N; sv = 2'b11;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      settle();
      tests++;
      if (obs_v !== exp_v) begin
        fails++;
        $display("FAIL alternate_outputs t=%0t got=%h want=%h", $time, obs_v, exp_v);
      end
      fin = all_done();
      advance();
    end
    tests++;
    if (!fin) begin fails++; $display("FAIL alternate_timeout done=0 want=1"); end
    e = (got_gnt.size() != 4) ? 1 : 0;
    if (e == 0) foreach (want[i]) if (got_gnt[i] != want[i]) e++;
    tests++;
    if (e != 0) begin
      fails++;
      $display("FAIL alternate_grant_order got=%p want=%p", got_gnt, want);
    end
    e = log_errors();
    tests++;
    if (e != 0 || got_r0.size() != 2 * M || got_r1.size() != 2 * M) begin
      fails++;
      $display("FAIL alternate_data errors=%0d r0=%0d r1=%0d want 0/%0d/%0d", e, got_r0.size(), got_r1.size(), 2 * M, 2 * M);
    end
  endtask

  task automatic test_drain_toggle();
    bit fin = 0;
    int e;
    setup(2, 0, 0, 0, '0);
    left[0] = N; sv[0] = 1'b1;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      settle();
      tests++;
      if (obs_v !== exp_v) begin
        fails++;
        $display("FAIL toggle_outputs t=%0t got=%h want=%h", $time, obs_v, exp_v);
      end
      fin = all_done();
      advance();
    end
    tests++;
    if (!fin) begin fails++; $display("FAIL toggle_timeout done=0 want=1"); end
    e = log_errors();
    tests++;
    if (e != 0 || got_r0.size() != M) begin
      fails++;
      $display("FAIL toggle_data errors=%0d r0=%0d want 0/%0d", e, got_r0.size(), M);
    end
  endtask

  task automatic test_late_request();
    bit fin = 0, late = 0;
    int e;
    setup(0, 1, 1, 0, '0);
    left[0] = N; sv[0] = 1'b1;
    for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
      if (!late && own == 0 && nin == 3) begin
        late = 1; left[1] = N; sv[1] = 1'b1;
      end
      settle();
      tests++;
      if (obs_v !== exp_v) begin
        fails++;
        $display("FAIL late_outputs t=%0t got=%h want=%h", $time, obs_v, exp_v);
      end
      fin = all_done();
      advance();
    end
    tests++;
    if (!fin || !late) begin fails++; $display("FAIL late_timeout done=%0d late=%0d want 1/1", fin, late); end
    tests++;
    if (got_gnt.size() != 2 || got_gnt[0] != 0 || got_gnt[1] != 1) begin
      fails++;
      $display("FAIL late_grant_order got=%p want 0,1", got_gnt);
    end
    e = log_errors();
    tests++;
    if (e != 0) begin fails++; $display("FAIL late_data errors=%0d want 0", e); end
  endtask

  task automatic test_reset_mid();
    bit hit = 0, fin = 0;
    int e;
    setup(0, 0, 0, 0, '0);
    left[0] = N; sv[0] = 1'b1;
    for (int cyc = 0; cyc < 400 && !hit; cyc++) begin
      if (own == 0 && nin == N && nout == 5) begin
        hit = 1; reset = 1'b1; sv = 2'b00; left[0] = 0;
        eng_m_valid = 1'b0; eng_pend = 0; eng_cnt = 0;
      end
      settle();
      tests++;
      if (obs_v !== exp_v) begin
        fails++;
        $display("FAIL resetmid_outputs t=%0t got=%h want=%h", $time, obs_v, exp_v);
      end
      advance();
    end
    reset = 1'b0;
    tests++;
    if (!hit) begin fails++; $display("FAIL resetmid_timeout reached=0 want=1"); end
    settle();
    tests++;
    if (obs_v !== 56'h0) begin
      fails++;
      $display("FAIL resetmid_after got=%h want=0", obs_v);
    end
    advance();
    clear_logs();
    left[1] = N; sv[1] = 1'b1;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      settle();
      tests++;
      if (obs_v !== exp_v) begin
        fails++;
        $display("FAIL resetmid_fresh t=%0t got=%h want=%h", $time, obs_v, exp_v);
      end
      fin = all_done();
      advance();
    end
    tests++;
    if (!fin || got_gnt.size() != 1 || got_gnt[0] != 1) begin
      fails++;
      $display("FAIL resetmid_regrant done=%0d grants=%p want 1/1", fin, got_gnt);
    end
    e = log_errors();
    tests++;
    if (e != 0 || got_r1.size() != M) begin
      fails++;
      $display("FAIL resetmid_data errors=%0d r1=%0d want 0/%0d", e, got_r1.size(), M);
    end
  endtask

  task automatic test_early_result();
    bit fin = 0;
    int e;
    setup(0, 1, 0, 0, '0);
    early = 1'b1; eng_m_valid = 1'b1;
    left[1] = N; sv[1] = 1'b1;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      settle();
      tests++;
      if (obs_v !== exp_v) begin
        fails++;
        $display("FAIL early_outputs t=%0t got=%h want=%h", $time, obs_v, exp_v);
      end
      fin = all_done();
      advance();
    end
    tests++;
    if (!fin) begin fails++; $display("FAIL early_timeout done=0 want=1"); end
    e = log_errors();
    tests++;
    if (e != 0 || got_r1.size() != M) begin
      fails++;
      $display("FAIL early_data errors=%0d r1=%0d want 0/%0d", e, got_r1.size(), M);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      bit fin = 0;
      int e;
      setup($urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, '0);
      left[0] = $urandom_range(0, 2) * N;
      left[1] = $urandom_range(1, 2) * N;
      sv[0] = (left[0] > 0); sv[1] = 1'b1;
      for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
        settle();
        tests++;
        if (obs_v !== exp_v) begin
          fails++;
          $display("FAIL random_outputs round %0d t=%0t got=%h want=%h", r, $time, obs_v, exp_v);
        end
        fin = all_done();
        advance();
      end
      tests++;
      if (!fin) begin fails++; $display("FAIL random_timeout round %0d done=0 want=1", r); end
      e = log_errors();
      tests++;
      if (e != 0) begin fails++; $display("FAIL random_data round %0d errors=%0d want 0", r, e); end
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    reset = 1'b1; sv = 2'b00; mr = 2'b11; sd[0] = '0; sd[1] = '0;
    eng_s_ready = 1'b0; eng_m_valid = 1'b0; eng_data_out = '0;
    own = -1; nin = 0; nout = 0; prio = 0;
    left[0] = 0; left[1] = 0; mr_mode = 0;
    sready_rand = 0; eng_rand = 0; eng_seq = 0; early = 0;
    eng_cnt = 0; eng_pend = 0; eng_next = '0; prev_busy = 1'b0;
    dsx[0] = 0; dsx[1] = 0; dein = 0; deout = 0;
    test_reset();
    test_single();
    test_alternate();
    test_drain_toggle();
    test_late_request();
    test_reset_mid();
    test_early_result();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
